// File: rtl/serial_deserializer_pkg.sv
// Shared types and constants for the serial deserializer and its transmitter peer.
package serial_deserializer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // Bit-order encoding, identical on the transmitter side of the link.
    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_deserializer_if.sv
// Bundle of the serial-link inputs and the parallel valid/ready outputs.
//
// Handshake: data_o carries a word whenever valid_o is 1; the word is
// transferred on the rising Clk edge where valid_o && ready_i. While
// valid_o && !ready_i, data_o and valid_o are held stable.
interface serial_deserializer_if
    import serial_deserializer_pkg::*;
#(
    parameter int BUSWIDTH = 8
);
    logic                serial_i;
    logic                bit_valid_i;
    logic                sync_i;
    logic                dir_i;
    logic [BUSWIDTH-1:0] data_o;
    logic                valid_o;
    logic                ready_i;
    logic                overrun_o;
    logic                clr_err_i;
    logic                frame_err_o;
    logic                busy_o;
    state_t              state_dbg;

    // Stimulus/consumer side.
    modport master (
        output serial_i, bit_valid_i, sync_i, dir_i, ready_i, clr_err_i,
        input  data_o, valid_o, overrun_o, frame_err_o, busy_o, state_dbg
    );

    // Deserializer side.
    modport slave (
        input  serial_i, bit_valid_i, sync_i, dir_i, ready_i, clr_err_i,
        output data_o, valid_o, overrun_o, frame_err_o, busy_o, state_dbg
    );
endinterface

// File: rtl/serial_deserializer_sipo_shift_reg.sv
// WIDTH-bit serial-in shift register with enable, direction and sync clear.
// word_next exposes the value the register takes on an enabled edge, so the
// caller can capture a completed word on the same edge as its last bit.
module sipo_shift_reg
    import serial_deserializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             dir,
    input  logic             din,
    output logic [WIDTH-1:0] word_next
);
    logic [WIDTH-1:0] q;

    assign word_next = (dir == DIR_LSB_FIRST) ? {din, q[WIDTH-1:1]}
                                              : {q[WIDTH-2:0], din};

    // Shift one bit per enabled cycle; clear has priority.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= word_next;
        end
    end
endmodule

// File: rtl/serial_deserializer.sv
// Serial-in, parallel-out receiver with valid/ready output, sticky overrun
// flag and a one-cycle framing-error pulse on a mid-word sync.
module serial_deserializer
    import serial_deserializer_pkg::*;
#(
    parameter  int BUSWIDTH = 8,
    localparam int CNTW     = $clog2(BUSWIDTH + 1)
) (
    input  logic                  Clk,
    input  logic                  Rst,
    serial_deserializer_if.slave  bus
);
    state_t              state;
    logic [CNTW-1:0]     cnt;
    logic                dir_q;
    logic [BUSWIDTH-1:0] data_q;
    logic                valid_q;
    logic                overrun_q;
    logic                frame_err_q;

    logic                start;
    logic                shift_en;
    logic                eff_dir;
    logic                last_bit;
    logic                can_load;
    logic [BUSWIDTH-1:0] word_next;

    // A sync bit always begins a word; other bits count only inside a frame.
    assign start    = bus.bit_valid_i & bus.sync_i;
    assign shift_en = bus.bit_valid_i & ((state == RECV) | bus.sync_i);
    assign eff_dir  = start ? bus.dir_i : dir_q;
    // A sync bit is always bit 0, so it can never complete a word (WIDTH >= 2).
    assign last_bit = shift_en & ~start & (cnt == CNTW'(BUSWIDTH - 1));
    // The holding register is free if empty or being drained this edge.
    assign can_load = ~valid_q | bus.ready_i;

    sipo_shift_reg #(.WIDTH(BUSWIDTH)) u_sr (
        .clk       (Clk),
        .clr       (Rst),
        .en        (shift_en),
        .dir       (eff_dir),
        .din       (bus.serial_i),
        .word_next (word_next)
    );

    // FSM, bit counter, output holding register and error flags.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= IDLE;
            cnt         <= '0;
            dir_q       <= DIR_MSB_FIRST;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= start & (state == RECV) & (cnt != '0);

            if (shift_en) begin
                state <= RECV;
                dir_q <= eff_dir;
                if (start) begin
                    cnt <= CNTW'(1);
                end else if (last_bit) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNTW'(1);
                end
            end

            if (last_bit && can_load) begin
                data_q  <= word_next;
                valid_q <= 1'b1;
            end else if (valid_q && bus.ready_i) begin
                valid_q <= 1'b0;
            end

            // Set wins over clear when both happen on the same edge.
            if (last_bit && !can_load) begin
                overrun_q <= 1'b1;
            end else if (bus.clr_err_i) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.data_o      = data_q;
    assign bus.valid_o     = valid_q;
    assign bus.overrun_o   = overrun_q;
    assign bus.frame_err_o = frame_err_q;
    assign bus.busy_o      = (state == RECV) && (cnt != '0);
    assign bus.state_dbg   = state;
endmodule

// File: tb/tb_serial_deserializer.sv
// Self-checking bench for serial_deserializer (BUSWIDTH = 8).
module tb_serial_deserializer;
    import serial_deserializer_pkg::*;

    localparam int W = 8;

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    serial_deserializer_if #(.BUSWIDTH(W)) ifc ();

    serial_deserializer #(.BUSWIDTH(W)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (ifc)
    );

    // ---------------- clock ----------------
    always #5 Clk = ~Clk;

    // ---------------- counters ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Words are kept as a list of received bits and assembled only when full.
    logic          bits[$];
    bit            m_in_frame;
    logic          m_dir;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ovr;
    logic          m_fe;
    logic [W-1:0]  exp_q[$];

    task automatic model_reset();
        bits.delete();
        exp_q.delete();
        m_in_frame = 0;
        m_dir      = DIR_MSB_FIRST;
        m_data     = '0;
        m_valid    = 1'b0;
        m_ovr      = 1'b0;
        m_fe       = 1'b0;
    endtask

    function automatic logic [W-1:0] assemble(input logic d);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            if (d == DIR_MSB_FIRST) w[W-1-i] = bits[i];
            else                    w[i]     = bits[i];
        end
        return w;
    endfunction

    task automatic model_edge(input logic bv, input logic sy, input logic d,
                              input logic s, input logic rdy, input logic clr);
        bit           done;
        logic [W-1:0] word;
        done = 0;
        word = '0;
        m_fe = 1'b0;
        if (bv) begin
            if (sy) begin
                if (m_in_frame && bits.size() != 0) m_fe = 1'b1;
                bits.delete();
                m_dir      = d;
                m_in_frame = 1;
                bits.push_back(s);
            end else if (m_in_frame) begin
                bits.push_back(s);
            end
            if (bits.size() == W) begin
                word = assemble(m_dir);
                bits.delete();
                done = 1;
            end
        end
        if (m_valid && rdy) void'(exp_q.pop_front());
        if (done && (!m_valid || rdy)) begin
            m_data  = word;
            m_valid = 1'b1;
            exp_q.push_back(word);
        end else if (done) begin
            m_ovr = 1'b1;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        if (!(done && m_valid && !rdy && word != m_data) && clr && !(done && !( !m_valid || rdy)))
            m_ovr = 1'b0;
    endtask

    // ---------------- driver ----------------
    // Drive one cycle of inputs, advance one edge, compare against the model.
    task automatic step(input logic rst_v, input logic bv, input logic sy, input logic d,
                        input logic s, input logic rdy, input logic clr);
        Rst             = rst_v;
        ifc.bit_valid_i = bv;
        ifc.sync_i      = sy;
        ifc.dir_i       = d;
        ifc.serial_i    = s;
        ifc.ready_i     = rdy;
        ifc.clr_err_i   = clr;
        if (!rst_v && m_valid && rdy && exp_q.size() > 0)
            chk("accepted_word", ifc.data_o, exp_q[0]);
        if (rst_v) model_reset();
        else       model_edge(bv, sy, d, s, rdy, clr);
        @(posedge Clk);
        #1;
        chk("data_o",      ifc.data_o,      m_data);
        chk("valid_o",     ifc.valid_o,     m_valid);
        chk("overrun_o",   ifc.overrun_o,   m_ovr);
        chk("frame_err_o", ifc.frame_err_o, m_fe);
        chk("busy_o",      ifc.busy_o,      m_in_frame && bits.size() != 0);
        chk("state_recv",  ifc.state_dbg == RECV, m_in_frame);
    endtask

    task automatic idle(input logic rdy);
        step(0, 0, 0, 0, 0, rdy, 0);
    endtask

    // Send one word; sync on the first bit if requested, optional idle gaps,
    // ready held at rdy except on the final bit where rdy_last is used.
    task automatic send_word(input logic [W-1:0] w, input logic d, input bit with_sync,
                             input bit gaps, input logic rdy, input logic rdy_last);
        logic b;
        for (int i = 0; i < W; i++) begin
            b = (d == DIR_LSB_FIRST) ? w[i] : w[W-1-i];
            step(0, 1, (i == 0) && with_sync, d, b, (i == W-1) ? rdy_last : rdy, 0);
            if (gaps && i != W-1) idle(rdy);
        end
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic         bv, sy, d, s, rdy;
        logic         exp_valid;
        logic [W-1:0] exp_data;
        logic         exp_busy;
    } vec_t;

    vec_t tbl[9];

    initial begin
        ifc.serial_i = 0; ifc.bit_valid_i = 0; ifc.sync_i = 0; ifc.dir_i = 0;
        ifc.ready_i = 0;  ifc.clr_err_i = 0;
        model_reset();

        // Reset
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 1, 0, 0);
        chk("reset_data",  ifc.data_o,  0);
        chk("reset_valid", ifc.valid_o, 0);
        chk("reset_busy",  ifc.busy_o,  0);

        // MSB-first 0xA5 (1,0,1,0,0,1,0,1), ready high
        tbl[0] = '{1, 1, 0, 1, 1, 0, 8'h00, 1};
        tbl[1] = '{1, 0, 0, 0, 1, 0, 8'h00, 1};
        tbl[2] = '{1, 0, 0, 1, 1, 0, 8'h00, 1};
        tbl[3] = '{1, 0, 0, 0, 1, 0, 8'h00, 1};
        tbl[4] = '{1, 0, 0, 0, 1, 0, 8'h00, 1};
        tbl[5] = '{1, 0, 0, 1, 1, 0, 8'h00, 1};
        tbl[6] = '{1, 0, 0, 0, 1, 0, 8'h00, 1};
        tbl[7] = '{1, 0, 0, 1, 1, 1, 8'hA5, 0};
        tbl[8] = '{0, 0, 0, 0, 1, 0, 8'hA5, 0};
        for (int i = 0; i < 9; i++) begin
            step(0, tbl[i].bv, tbl[i].sy, tbl[i].d, tbl[i].s, tbl[i].rdy, 0);
            chk("tbl_valid", ifc.valid_o, tbl[i].exp_valid);
            chk("tbl_data",  ifc.data_o,  tbl[i].exp_data);
            chk("tbl_busy",  ifc.busy_o,  tbl[i].exp_busy);
        end

        // LSB-first 0x3C with gaps
        send_word(8'h3C, DIR_LSB_FIRST, 1, 1, 0, 0);
        chk("lsb_data",  ifc.data_o,  8'h3C);
        chk("lsb_valid", ifc.valid_o, 1);
        idle(1);

        // Overrun: 0x11 then 0x22 streamed with ready low
        send_word(8'h11, DIR_MSB_FIRST, 1, 0, 0, 0);
        send_word(8'h22, DIR_MSB_FIRST, 0, 0, 0, 0);
        chk("ovr_data", ifc.data_o,    8'h11);
        chk("ovr_flag", ifc.overrun_o, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("ovr_clr",  ifc.overrun_o, 0);
        idle(1);
        chk("ovr_drain", ifc.valid_o, 0);

        // Back-to-back: ready only on the edge 0x22 completes
        send_word(8'h11, DIR_MSB_FIRST, 1, 0, 0, 0);
        send_word(8'h22, DIR_MSB_FIRST, 0, 0, 0, 1);
        chk("b2b_data",  ifc.data_o,    8'h22);
        chk("b2b_valid", ifc.valid_o,   1);
        chk("b2b_ovr",   ifc.overrun_o, 0);
        idle(1);

        // Overrun with clear on the same edge: set wins
        send_word(8'h33, DIR_MSB_FIRST, 1, 0, 0, 0);
        for (int i = 0; i < W; i++)
            step(0, 1, 0, 0, 1'(i), 0, (i == W-1) ? 1'b1 : 1'b0);
        chk("ovr_set_wins", ifc.overrun_o, 1);
        step(0, 0, 0, 0, 0, 1, 1);

        // Sync mid-word
        step(0, 1, 1, 0, 1, 1, 0);
        step(0, 1, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 1, 1, 0);
        step(0, 1, 1, 0, 1, 1, 0);
        chk("mid_sync_fe", ifc.frame_err_o, 1);
        for (int i = 1; i < W; i++) begin
            step(0, 1, 0, 0, (i < 4) ? 1'b1 : 1'b0, 1, 0);
            chk("mid_sync_fe_once", ifc.frame_err_o, 0);
        end
        chk("mid_sync_data", ifc.data_o, 8'hF0);
        idle(1);

        // Reset mid-word, then unsynced bits are ignored
        send_word(8'hFF, DIR_MSB_FIRST, 1, 0, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 1, (i == 0) ? 1'b1 : 1'b0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2*W; i++) step(0, 1, 0, 0, 1, 1, 0);
        chk("rst_mid_valid", ifc.valid_o, 0);
        chk("rst_mid_data",  ifc.data_o,  0);
        send_word(8'h5A, DIR_MSB_FIRST, 1, 0, 0, 0);
        chk("post_rst_data", ifc.data_o, 8'h5A);
        idle(1);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
